// File: rtl/ch_nibble_packer.sv
// ch_nibble_packer
//   Sits on the dequeue side of the 4-bit valid/ready queue and packs RATIO
//   consecutive nibbles into one WORD-bit word, little-endian (first nibble
//   in bits [3:0]). A partial word is flushed, zero-padded, after TIMEOUT
//   idle cycles (TIMEOUT=0 never flushes a partial word).
//
// Ports
//   clk           rising-edge clock
//   reset         async active-low reset (released synchronously upstream)
//   io_in_valid   nibble offered by the queue
//   io_in_data    nibble value (ignored unless accepted)
//   io_in_ready   nibble accepted when high together with io_in_valid
//   io_out_ready  downstream takes the word
//   io_out_valid  word available (held until taken)
//   io_out_data   packed word, unfilled slots read 0
//   io_out_count  meaningful nibbles in io_out_data, 1..RATIO (0 when idle)

module ch_nibble_packer #(
    parameter  int RATIO   = 4,
    parameter  int TIMEOUT = 16,
    localparam int WORD    = 4 * RATIO,
    localparam int CW      = $clog2(RATIO) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            io_in_valid,
    input  logic [3:0]      io_in_data,
    output logic            io_in_ready,
    input  logic            io_out_ready,
    output logic            io_out_valid,
    output logic [WORD-1:0] io_out_data,
    output logic [CW-1:0]   io_out_count
);

    // A zero TIMEOUT would give a zero-width timer; keep one unused bit.
    localparam int            TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] C_LAST = CW'(RATIO - 1);
    localparam logic [CW-1:0] C_FULL = CW'(RATIO);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                 state, state_n;
    logic [RATIO-1:0][3:0]  acc, acc_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [TW-1:0]          timer, timer_n;
    logic                   in_fire, out_fire;

    // Only combinational path from the output side: out_ready -> in_ready,
    // so a draining word and a new nibble can fire in the same cycle.
    assign io_in_ready  = (state == FILL) || io_out_ready;
    assign io_out_valid = (state == HOLD);
    assign io_out_data  = acc;
    assign io_out_count = io_out_valid ? cnt : '0;

    assign in_fire  = io_in_valid && io_in_ready;
    assign out_fire = io_out_valid && io_out_ready;

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = cnt;
        timer_n = timer;
        case (state)
            FILL: begin
                if (in_fire) begin
                    for (int i = 0; i < RATIO; i++)
                        if (cnt == CW'(i)) acc_n[i] = io_in_data;
                    timer_n = '0;
                    if (cnt == C_LAST) begin
                        cnt_n   = C_FULL;
                        state_n = HOLD;
                    end else begin
                        cnt_n = cnt + CW'(1);
                    end
                end else if (cnt != '0 && TIMEOUT > 0) begin
                    // Accept beats expiry: this branch only runs without in_fire.
                    if (timer == T_LAST) begin
                        timer_n = '0;
                        state_n = HOLD;
                    end else begin
                        timer_n = timer + TW'(1);
                    end
                end
            end
            HOLD: begin
                // Without out_fire everything (timer included) is frozen and
                // in_ready is low, so nothing can be accepted here.
                if (out_fire) begin
                    acc_n   = '0;
                    timer_n = '0;
                    state_n = FILL;
                    if (in_fire) begin
                        acc_n[0] = io_in_data;
                        cnt_n    = CW'(1);
                    end else begin
                        cnt_n = '0;
                    end
                end
            end
            default: state_n = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FILL;
            acc   <= '0;
            cnt   <= '0;
            timer <= '0;
        end else begin
            state <= state_n;
            acc   <= acc_n;
            cnt   <= cnt_n;
            timer <= timer_n;
        end
    end

endmodule

// File: tb/tb_ch_nibble_packer.sv
module tb_ch_nibble_packer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    always #5 clk = ~clk;

    // main DUT: RATIO=4, TIMEOUT=8
    logic        in_valid, in_ready, out_ready, out_valid;
    logic [3:0]  in_data;
    logic [15:0] out_data;
    logic [2:0]  out_count;

    // second DUT: RATIO=4, TIMEOUT=0
    logic        z_in_valid, z_in_ready, z_out_ready, z_out_valid;
    logic [3:0]  z_in_data;
    logic [15:0] z_out_data;
    logic [2:0]  z_out_count;

    ch_nibble_packer #(.RATIO(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset(reset),
        .io_in_valid(in_valid), .io_in_data(in_data), .io_in_ready(in_ready),
        .io_out_ready(out_ready), .io_out_valid(out_valid),
        .io_out_data(out_data), .io_out_count(out_count)
    );

    ch_nibble_packer #(.RATIO(4), .TIMEOUT(0)) dut_z (
        .clk(clk), .reset(reset),
        .io_in_valid(z_in_valid), .io_in_data(z_in_data), .io_in_ready(z_in_ready),
        .io_out_ready(z_out_ready), .io_out_valid(z_out_valid),
        .io_out_data(z_out_data), .io_out_count(z_out_count)
    );

    int n_chk = 0;
    int n_bad = 0;
    int stalls = 0;

    typedef struct packed {
        logic [15:0] data;
        logic [2:0]  cnt;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every word taken by downstream is matched against the queue.
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_extra", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_data", 32'(out_data), 32'(mon_e.data));
                chk("sb_cnt", 32'(out_count), 32'(mon_e.cnt));
            end
        end
    end

    // Offer one nibble and wait (bounded) until it is accepted. Inputs move
    // 1ns after posedge; in_ready is sampled at negedge.
    task automatic send(input logic [3:0] n);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = n;
        for (int k = 0; k < 50 && !ok; k++) begin
            @(negedge clk);
            ok = in_ready;
            if (!ok) stalls++;
            @(posedge clk);
            #1;
        end
        if (!ok) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic z_send(input logic [3:0] n);
        z_in_valid = 1'b1;
        z_in_data  = n;
        @(negedge clk);
        chk("z_rdy", 32'(z_in_ready), 32'd1);
        @(posedge clk);
        #1;
        z_in_valid = 1'b0;
        z_in_data  = 4'($urandom);
    endtask

    task automatic go_idle();
        in_valid = 1'b0;
        in_data  = 4'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        bit seen;
        logic [3:0] nibs [8];

        in_valid = 0; in_data = 0; out_ready = 1;
        z_in_valid = 0; z_in_data = 0; z_out_ready = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_vld", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_cnt", 32'(out_count), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_rdy", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // T1: single full word, 1-cycle latency, 1-cycle pulse
        sb.push_back(exp_t'{16'h4321, 3'd4});
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        go_idle();
        @(negedge clk);
        chk("t1_vld", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("t1_pulse", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // T2: back-to-back words, no bubbles
        sb.push_back(exp_t'{16'hDCBA, 3'd4});
        sb.push_back(exp_t'{16'h10FE, 3'd4});
        nibs = '{4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
        stalls = 0;
        foreach (nibs[i]) send(nibs[i]);
        go_idle();
        chk("t2_stall", 32'(stalls), 32'd0);
        @(negedge clk);
        chk("t2_vld", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        // T3: partial word flushed after timeout
        sb.push_back(exp_t'{16'h0065, 3'd2});
        send(4'h5); send(4'h6);
        go_idle();
        lat = 0;
        for (int k = 1; k <= 30 && lat == 0; k++) begin
            @(negedge clk);
            if (out_valid) lat = k;
        end
        chk("t3_lat", 32'(lat), 32'd9);
        @(posedge clk); #1;

        // T4: backpressure on a full word, then drain with same-cycle accept
        sb.push_back(exp_t'{16'h4321, 3'd4});
        sb.push_back(exp_t'{16'h6789, 3'd4});
        out_ready = 1'b0;
        send(4'h1); send(4'h2); send(4'h3); send(4'h4);
        in_valid = 1'b1;
        in_data  = 4'h9;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t4_rdy", 32'(in_ready), 32'd0);
            chk("t4_vld", 32'(out_valid), 32'd1);
            chk("t4_data", 32'(out_data), 32'h4321);
            chk("t4_cnt", 32'(out_count), 32'd4);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        stalls = 0;
        send(4'h9); send(4'h8); send(4'h7); send(4'h6);
        go_idle();
        chk("t4_stall", 32'(stalls), 32'd0);
        @(negedge clk);
        chk("t4_vld2", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        // T5: async reset mid-word discards the partial word
        send(4'hA); send(4'hB); send(4'hC);
        go_idle();
        #2 reset = 1'b0;
        #1;
        chk("t5_vld", 32'(out_valid), 32'd0);
        chk("t5_data", 32'(out_data), 32'd0);
        chk("t5_cnt", 32'(out_count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        sb.push_back(exp_t'{16'h7777, 3'd4});
        send(4'h7); send(4'h7); send(4'h7); send(4'h7);
        go_idle();
        @(negedge clk);
        chk("t5_vld2", 32'(out_valid), 32'd1);
        @(posedge clk); #1;

        // T6: TIMEOUT=0 never flushes a partial word
        z_send(4'h1); z_send(4'h2);
        seen = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (z_out_valid) seen = 1'b1;
        end
        chk("t6_quiet", 32'(seen), 32'd0);
        @(posedge clk); #1;
        z_send(4'h3); z_send(4'h4);
        @(negedge clk);
        chk("t6_vld", 32'(z_out_valid), 32'd1);
        chk("t6_data", 32'(z_out_data), 32'h4321);
        chk("t6_cnt", 32'(z_out_count), 32'd4);

        repeat (3) @(posedge clk);
        chk("sb_left", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
